io_port_bridge: RTL

//  Synthesizable multi-channel I/O bridge between the processor core's address-coded I/O bus
//  (proc_req_in / proc_out_en / proc_io_in / proc_io_out) and streaming peripherals.

---
 rtl/io_bridge_pkg.sv | 20 ++
 rtl/io_sync_fifo.sv | 54 +++++
 rtl/io_port_bridge.sv | 139 +++++++++++++
 3 files changed

// File: rtl/io_bridge_pkg.sv
// Shared constants and helpers for the I/O port bridge: address coding and width derivation.
package io_bridge_pkg;

    localparam int IDLE_ADDR = 0;

    // Address k+1 selects channel k; address 0 is idle.
    function automatic int addr_to_ch(input int a);
        return a - 1;
    endfunction

    // Width of an address field able to encode idle plus n channels.
    function automatic int addr_w(input int n);
        return (n + 1 > 1) ? $clog2(n + 1) : 1;
    endfunction

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is zero while empty so idle outputs read 0.
module io_sync_fifo
    import io_bridge_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic signed [DATA_W-1:0] data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic signed [DATA_W-1:0] head_o
);

    localparam int AW = ptr_w(DEPTH) - 1;

    logic [AW:0]              wptr_q, wptr_d;
    logic [AW:0]              rptr_q, rptr_d;
    logic signed [DATA_W-1:0] mem_q [DEPTH];
    logic                     wr_en, rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    // A full FIFO still accepts a push when its head leaves in the same cycle.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/io_port_bridge.sv
// Multi-channel bridge between the core's address-coded I/O bus and buffered streaming peripherals.
module io_port_bridge
    import io_bridge_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_IN     = 2,
    parameter int NUM_OUT    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int IN_AW      = addr_w(NUM_IN),
    parameter int OUT_AW     = addr_w(NUM_OUT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IN_AW-1:0]            proc_req_in,
    output logic signed [DATA_W-1:0]    proc_io_in,
    input  logic [OUT_AW-1:0]           proc_out_en,
    input  logic signed [DATA_W-1:0]    proc_io_out,
    input  logic [NUM_IN*DATA_W-1:0]    in_data,
    input  logic [NUM_IN-1:0]           in_valid,
    output logic [NUM_IN-1:0]           in_ready,
    output logic [NUM_OUT*DATA_W-1:0]   out_data,
    output logic [NUM_OUT-1:0]          out_valid,
    input  logic [NUM_OUT-1:0]          out_ready,
    output logic [NUM_IN-1:0]           err_under,
    output logic [NUM_OUT-1:0]          err_over,
    output logic                        err_addr,
    input  logic                        err_clr
);

    logic [NUM_IN-1:0]        in_full, in_empty, in_pop, in_push;
    logic signed [DATA_W-1:0] in_head [NUM_IN];
    logic [NUM_OUT-1:0]       out_full, out_empty, out_pop, out_push;
    logic signed [DATA_W-1:0] out_head [NUM_OUT];

    logic                     rd_req, rd_bad, wr_req, wr_bad, rd_hit, rd_empty;
    int                       rd_ch, wr_ch;
    logic signed [DATA_W-1:0] rd_head;
    logic signed [DATA_W-1:0] hold_q, hold_d;
    logic [NUM_IN-1:0]        err_under_q, err_under_d, under_set;
    logic [NUM_OUT-1:0]       err_over_q, err_over_d, over_set;
    logic                     err_addr_q, err_addr_d;

    genvar g;
    generate
        for (g = 0; g < NUM_IN; g++) begin : g_in
            io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk    (clk),
                .rst    (rst),
                .push_i (in_push[g]),
                .data_i (in_data[g*DATA_W +: DATA_W]),
                .pop_i  (in_pop[g]),
                .full_o (in_full[g]),
                .empty_o(in_empty[g]),
                .head_o (in_head[g])
            );
        end
        for (g = 0; g < NUM_OUT; g++) begin : g_out
            io_sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
                .clk    (clk),
                .rst    (rst),
                .push_i (out_push[g]),
                .data_i (proc_io_out),
                .pop_i  (out_pop[g]),
                .full_o (out_full[g]),
                .empty_o(out_empty[g]),
                .head_o (out_head[g])
            );
            assign out_data[g*DATA_W +: DATA_W] = out_head[g];
        end
    endgenerate

    assign in_ready  = ~in_full;
    assign in_push   = in_valid & ~in_full;
    assign out_valid = ~out_empty;
    assign out_pop   = out_ready & ~out_empty;

    assign rd_req = (proc_req_in != IN_AW'(IDLE_ADDR)) && (proc_req_in <= IN_AW'(NUM_IN));
    assign rd_bad = (proc_req_in > IN_AW'(NUM_IN));
    assign wr_req = (proc_out_en != OUT_AW'(IDLE_ADDR)) && (proc_out_en <= OUT_AW'(NUM_OUT));
    assign wr_bad = (proc_out_en > OUT_AW'(NUM_OUT));
    assign rd_ch  = addr_to_ch(int'(proc_req_in));
    assign wr_ch  = addr_to_ch(int'(proc_out_en));

    // Read mux: an empty or idle read leaves the last returned word on proc_io_in.
    always_comb begin
        rd_head   = '0;
        rd_empty  = 1'b1;
        in_pop    = '0;
        under_set = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (rd_req && rd_ch == k) begin
                rd_head      = in_head[k];
                rd_empty     = in_empty[k];
                in_pop[k]    = !in_empty[k] && !rst;
                under_set[k] = in_empty[k];
            end
        end
        rd_hit     = rd_req && !rd_empty && !rst;
        proc_io_in = rd_hit ? rd_head : hold_q;
        hold_d     = proc_io_in;
    end

    always_comb begin
        out_push = '0;
        over_set = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (wr_req && wr_ch == k) begin
                out_push[k] = 1'b1;
                over_set[k] = out_full[k] && !out_pop[k];
            end
        end
    end

    // Sticky errors; a same-cycle clear beats a new set.
    always_comb begin
        err_under_d = err_clr ? '0 : (err_under_q | under_set);
        err_over_d  = err_clr ? '0 : (err_over_q | over_set);
        err_addr_d  = err_clr ? 1'b0 : (err_addr_q | rd_bad | wr_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            err_under_q <= '0;
            err_over_q  <= '0;
            err_addr_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            err_under_q <= err_under_d;
            err_over_q  <= err_over_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_under = err_under_q;
    assign err_over  = err_over_q;
    assign err_addr  = err_addr_q;

endmodule
